// File: rtl/pd_pkg.sv
// Shared definitions for the serial pattern detector.
//   PD_N / PD_PATTERN : default pattern width and pattern (MSB = first bit received)
//   PD_FILL_W         : fill counter width for the default width
//   fill_state_t      : fill-state decode (EMPTY / FILLING / ARMED)
//   pd_fill_w()       : fill counter width for an arbitrary pattern width
package pd_pkg;

  localparam int unsigned     PD_N       = 4;
  localparam logic [PD_N-1:0] PD_PATTERN = 4'b1011;
  localparam int unsigned     PD_FILL_W  = $clog2(PD_N + 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } fill_state_t;

  function automatic int unsigned pd_fill_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_detector_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count up by one (held at all-ones once reached)
//   clr        : synchronous clear, wins over inc
//   count      : current count
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: matches an N-bit pattern in a registered serial
// bit stream (downstream of the single-bit D flip-flop stage).
//   clk       : clock, all state updates on rising edge
//   rst_n     : asynchronous active-low reset
//   bit_in    : serial data bit (upstream flip-flop Q)
//   bit_vld   : bit_in is accepted only when 1
//   clr       : synchronous clear of history, fill, detect and counter
//   detect    : registered one-cycle pulse per match
//   hist_out  : last N accepted bits, bit 0 newest
//   match_cnt : saturating match count
// Optional feature: define PD_MATCH_COUNT_EN to build the match counter;
// otherwise match_cnt is constant 0.
module serial_pattern_detector
  import pd_pkg::*;
#(
  parameter int unsigned     N       = PD_N,
  parameter logic [N-1:0]    PATTERN = N'(PD_PATTERN),
  parameter int unsigned     OVERLAP = 1,
  parameter int unsigned     CW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bit_in,
  input  logic          bit_vld,
  input  logic          clr,
  output logic          detect,
  output logic [N-1:0]  hist_out,
  output logic [CW-1:0] match_cnt
);

  localparam int unsigned    FW        = pd_fill_w(N);
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);
  localparam logic [FW-1:0]  FILL_LAST = FW'(N - 1);

  logic [N-1:0]  hist;
  logic [N-1:0]  hist_nxt;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_nxt;
  logic          detect_q;
  logic          detect_nxt;
  logic [N-1:0]  window;
  logic          match;
  fill_state_t   state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     <= '0;
      fill     <= '0;
      detect_q <= 1'b0;
    end else begin
      hist     <= hist_nxt;
      fill     <= fill_nxt;
      detect_q <= detect_nxt;
    end
  end

  // Fill state is a pure decode of the fill count.
  always_comb begin
    state = FILLING;
    if (fill == '0) begin
      state = EMPTY;
    end else if (fill >= FILL_FULL) begin
      state = ARMED;
    end
  end

  // Next-state logic. The match is judged on the window that includes the
  // incoming bit, so fill must already hold N-1 bits; this keeps the
  // zero-initialised history from ever matching.
  always_comb begin
    window     = {hist[N-2:0], bit_in};
    match      = bit_vld && !clr && (fill >= FILL_LAST) && (window == PATTERN);
    hist_nxt   = hist;
    fill_nxt   = fill;
    detect_nxt = 1'b0;
    if (clr) begin
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (bit_vld) begin
      hist_nxt = window;
      unique case (state)
        EMPTY:   fill_nxt = FW'(1);
        FILLING: fill_nxt = fill + FW'(1);
        ARMED:   fill_nxt = FILL_FULL;
        default: fill_nxt = '0;
      endcase
      if (match && (OVERLAP == 0)) begin
        fill_nxt = '0;
      end
      detect_nxt = match;
    end
  end

  // Outputs
  always_comb begin
    detect   = detect_q;
    hist_out = hist;
  end

`ifdef PD_MATCH_COUNT_EN
  sat_counter #(
    .WIDTH(CW)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (match),
    .clr   (clr),
    .count (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed self-checking bench for serial_pattern_detector. Four instances
// share one input stream: default, non-overlapping, pattern 0011, and a
// 2-bit counter. Counter expectations are 0 when PD_MATCH_COUNT_EN is off.
module tb_serial_pattern_detector;

`ifdef PD_MATCH_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic bit_in;
  logic bit_vld;
  logic clr;

  logic       det_a, det_b, det_c, det_d;
  logic [3:0] hist_a, hist_b, hist_c, hist_d;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_pattern_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld), .clr(clr),
    .detect(det_a), .hist_out(hist_a), .match_cnt(cnt_a));

  serial_pattern_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CW(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld), .clr(clr),
    .detect(det_b), .hist_out(hist_b), .match_cnt(cnt_b));

  serial_pattern_detector #(.N(4), .PATTERN(4'b0011), .OVERLAP(1), .CW(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld), .clr(clr),
    .detect(det_c), .hist_out(hist_c), .match_cnt(cnt_c));

  serial_pattern_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CW(2)) dut_d (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld), .clr(clr),
    .detect(det_d), .hist_out(hist_d), .match_cnt(cnt_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, return at the next falling edge.
  task automatic step(input logic b, input logic v, input logic c);
    bit_in  = b;
    bit_vld = v;
    clr     = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bit_vld = 1'b0;
    clr     = 1'b0;
    bit_in  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [6:0]  s2  = 7'b1011011;
  logic [6:0]  ea2 = 7'b0001001;
  logic [6:0]  eb2 = 7'b0001000;
  int b3[10] = '{1, 1, 1, 0, 1, 0, 0, 0, 1, 1};
  int v3[10] = '{1, 0, 0, 1, 1, 0, 0, 0, 1, 0};
  int h3[10] = '{1, 1, 1, 2, 5, 5, 5, 5, 11, 11};
  int d3[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic [5:0]  s4  = 6'b110011;
  logic [5:0]  ec4 = 6'b000001;
  logic [15:0] s5  = 16'b1011011011011011;

  initial begin
    rst_n   = 1'b0;
    bit_in  = 1'b0;
    bit_vld = 1'b0;
    clr     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset det_a",  32'(det_a),  32'd0);
    check("reset hist_a", 32'(hist_a), 32'd0);
    check("reset cnt_a",  32'(cnt_a),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Patterns 1 and 2: overlapping vs non-overlapping.
    for (int i = 6; i >= 0; i--) begin
      step(s2[i], 1'b1, 1'b0);
      check($sformatf("ovl det_a bit%0d", 7 - i), 32'(det_a), 32'(ea2[i]));
      check($sformatf("novl det_b bit%0d", 7 - i), 32'(det_b), 32'(eb2[i]));
      check($sformatf("p0011 det_c bit%0d", 7 - i), 32'(det_c), 32'd0);
      if (i == 3) check("hist_a after 1011", 32'(hist_a), 32'hB);
    end
    check("cnt_a two matches", 32'(cnt_a), CNT_ON ? 32'd2 : 32'd0);
    check("cnt_b one match",   32'(cnt_b), CNT_ON ? 32'd1 : 32'd0);
    check("hist_b shifts after match", 32'(hist_b), 32'hB);
    step(1'b0, 1'b0, 1'b0);
    check("det_a idle", 32'(det_a), 32'd0);

    step(1'b0, 1'b0, 1'b1);
    check("clr hist_a", 32'(hist_a), 32'd0);
    check("clr cnt_a",  32'(cnt_a),  32'd0);

    // Pattern 3: gaps in bit_vld.
    for (int i = 0; i < 10; i++) begin
      step(1'(b3[i]), 1'(v3[i]), 1'b0);
      check($sformatf("gap det_a step%0d", i), 32'(det_a), 32'(d3[i]));
      check($sformatf("gap hist_a step%0d", i), 32'(hist_a), 32'(h3[i]));
    end
    check("gap cnt_a", 32'(cnt_a), CNT_ON ? 32'd1 : 32'd0);

    // Pattern 4: 0011 right after reset; early window 0011 must not fire.
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      step(s4[i], 1'b1, 1'b0);
      check($sformatf("p0011 post-reset det_c bit%0d", 6 - i), 32'(det_c), 32'(ec4[i]));
    end

    // Pattern 5: saturation and clr-with-vld.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 15; i >= 0; i--) step(s5[i], 1'b1, 1'b0);
    check("cnt_d saturates", 32'(cnt_d), CNT_ON ? 32'd3 : 32'd0);
    check("cnt_a five",      32'(cnt_a), CNT_ON ? 32'd5 : 32'd0);
    check("det_d last match", 32'(det_d), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    check("clr+vld hist_a", 32'(hist_a), 32'd0);
    check("clr+vld det_a",  32'(det_a),  32'd0);
    check("clr+vld cnt_d",  32'(cnt_d),  32'd0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("dropped bit hist_a", 32'(hist_a), 32'h3);
    check("dropped bit det_a",  32'(det_a),  32'd0);

    // Pattern 6: asynchronous reset mid-pattern.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    bit_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst hist_a", 32'(hist_a), 32'd0);
    check("async rst det_a",  32'(det_a),  32'd0);
    check("async rst cnt_a",  32'(cnt_a),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check("post rst det_a",  32'(det_a),  32'd0);
    check("post rst hist_a", 32'(hist_a), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
